keypad_scan_ctrl: RTL and testbench

//  Sequencer for the 3x4 matrix keypad peripheral: drives rows one at a time, samples columns,

---
 rtl/keypad_pkg.sv | 49 ++++
 rtl/keypad_scan_ctrl_fifo.sv | 82 ++++++++
 rtl/keypad_scan_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_pkg : scan states, key codes and key-map decode function    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ROW0  = 3'd1,
    ST_ROW1  = 3'd2,
    ST_ROW2  = 3'd3,
    ST_ROW3  = 3'd4,
    ST_FRAME = 3'd5
  } scan_st_t;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_MULTI = 4'hE;
  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_HASH  = 4'hB;

  // Maps one row plus its active-low column sample to a key code;
  // anything other than exactly one low column yields KEY_NONE.
  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [2:0] col_n);
    logic [1:0] col;
    logic       hit;
    col = 2'd0;
    hit = 1'b1;
    case (col_n)
      3'b110:  col = 2'd0;
      3'b101:  col = 2'd1;
      3'b011:  col = 2'd2;
      default: hit = 1'b0;
    endcase
    if (!hit) begin
      decode_key = KEY_NONE;
    end else if (row != 2'd3) begin
      decode_key = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end else begin
      case (col)
        2'd0:    decode_key = KEY_STAR;
        2'd1:    decode_key = 4'h0;
        default: decode_key = KEY_HASH;
      endcase
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_ctrl_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_event_fifo : synchronous FIFO with registered show-ahead head  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module key_event_fifo #(
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] EMPTY_VAL = '1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic [CW-1:0]    w_remain;
  logic             w_push;
  logic             w_pop;

  assign full_o = (count_q == CW'(DEPTH));
  assign w_pop  = pop_i && (count_q != '0);
  // A pop frees a slot in the same cycle, so full + push + pop is accepted.
  assign w_push = push_i && (!full_o || w_pop);

  always_comb begin
    count_d  = count_q + CW'(w_push) - CW'(w_pop);
    rd_ptr_d = rd_ptr_q + AW'(w_pop);
    wr_ptr_d = wr_ptr_q + AW'(w_push);
    w_remain = count_q - CW'(w_pop);
    // The incoming word becomes the head when nothing older survives this cycle.
    if (count_d == '0) begin
      head_d = EMPTY_VAL;
    end else if (w_remain == '0) begin
      head_d = din_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= EMPTY_VAL;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scan_ctrl : 3x4 keypad row scanner, debouncer, event queue  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100_000,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  input  logic       rd_en,
  output logic [3:0] key_data,
  output logic       key_valid,
  output logic       overflow,
  output logic       interrupt
);

  localparam int unsigned    DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int unsigned    DB_W     = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE);
  localparam int unsigned    IC_W     = $clog2(INT_CYCLES + 1);
  localparam logic [IC_W-1:0] IC_MAX  = IC_W'(INT_CYCLES);
  localparam int unsigned    CNT_W    = $clog2(FIFO_DEPTH) + 1;

  scan_st_t          state_q, state_d;
  logic [2:0]        sync1_q, sync2_q;
  logic [DIV_W-1:0]  div_q;
  logic [2:0]        cols_q [4];
  logic [3:0]        prev_code_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [3:0]        stable_q;
  logic              overflow_q;
  logic [IC_W-1:0]   int_cnt_q;

  logic              w_in_row;
  logic [1:0]        w_row_idx;
  logic              w_tick;
  logic [3:0]        w_nlow;
  logic [1:0]        w_hit_row;
  logic [3:0]        w_frame_code;
  logic              w_push_req;
  logic              w_fifo_full;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_pop_acc;
  logic              w_push_acc;
  logic              w_drop;

  // Columns are asynchronous to clk; only the second stage is ever used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= col_n;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_ROW0;
      ST_ROW0:  if (w_tick) state_d = ST_ROW1;
      ST_ROW1:  if (w_tick) state_d = ST_ROW2;
      ST_ROW2:  if (w_tick) state_d = ST_ROW3;
      ST_ROW3:  if (w_tick) state_d = ST_FRAME;
      ST_FRAME: state_d = ST_ROW0;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Row 0 stays driven outside the row states so exactly one row is always low.
  always_comb begin
    row_n     = 4'b1110;
    w_row_idx = 2'd0;
    w_in_row  = 1'b0;
    unique case (state_q)
      ST_ROW0: begin row_n = 4'b1110; w_row_idx = 2'd0; w_in_row = 1'b1; end
      ST_ROW1: begin row_n = 4'b1101; w_row_idx = 2'd1; w_in_row = 1'b1; end
      ST_ROW2: begin row_n = 4'b1011; w_row_idx = 2'd2; w_in_row = 1'b1; end
      ST_ROW3: begin row_n = 4'b0111; w_row_idx = 2'd3; w_in_row = 1'b1; end
      default: begin row_n = 4'b1110; w_row_idx = 2'd0; w_in_row = 1'b0; end
    endcase
  end

  assign w_tick = w_in_row && (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (!w_in_row || w_tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        cols_q[r] <= 3'b111;
      end
    end else if (w_tick) begin
      cols_q[w_row_idx] <= sync2_q;
    end
  end

  always_comb begin
    w_nlow    = 4'd0;
    w_hit_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_nlow = w_nlow + {3'b000, ~cols_q[r][c]};
      end
      if (cols_q[r] != 3'b111) begin
        w_hit_row = 2'(r);
      end
    end
    if (w_nlow == 4'd0) begin
      w_frame_code = KEY_NONE;
    end else if (w_nlow == 4'd1) begin
      w_frame_code = decode_key(w_hit_row, cols_q[w_hit_row]);
    end else begin
      w_frame_code = KEY_MULTI;
    end
  end

  always_comb begin
    if (w_frame_code != prev_code_q) begin
      db_cnt_d = DB_W'(1);
    end else if (db_cnt_q != DB_MAX) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end else begin
      db_cnt_d = db_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code_q <= KEY_NONE;
      db_cnt_q    <= '0;
      stable_q    <= KEY_NONE;
    end else if (state_q == ST_FRAME) begin
      prev_code_q <= w_frame_code;
      db_cnt_q    <= db_cnt_d;
      if (db_cnt_d == DB_MAX) begin
        stable_q <= w_frame_code;
      end
    end
  end

  // Only a NONE -> real key transition of the stable code is a new press.
  assign w_push_req = (state_q == ST_FRAME) && (db_cnt_d == DB_MAX) &&
                      (stable_q == KEY_NONE) && (w_frame_code <= KEY_HASH);

  key_event_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .WIDTH     (4),
    .EMPTY_VAL (KEY_NONE)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push_req),
    .din_i   (w_frame_code),
    .pop_i   (rd_en),
    .head_o  (key_data),
    .valid_o (key_valid),
    .full_o  (w_fifo_full),
    .count_o (w_fifo_count)
  );

  assign w_pop_acc  = rd_en && (w_fifo_count != '0);
  assign w_push_acc = w_push_req && (!w_fifo_full || w_pop_acc);
  assign w_drop     = w_push_req && w_fifo_full && !w_pop_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (w_drop) begin
      overflow_q <= 1'b1;
    end else if (w_pop_acc) begin
      overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt_q <= '0;
    end else if (w_push_acc) begin
      int_cnt_q <= IC_MAX;
    end else if (int_cnt_q != '0) begin
      int_cnt_q <= int_cnt_q - IC_W'(1);
    end
  end

  assign overflow  = overflow_q;
  assign interrupt = (int_cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_keypad_scan_ctrl : keypad scanner bench with behavioural model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_keypad_scan_ctrl;

  localparam int SD        = 4;
  localparam int DB        = 3;
  localparam int FD        = 4;
  localparam int IC        = 2;
  localparam int FRAME_LEN = 4 * SD + 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_data;
  logic        key_valid;
  logic        overflow;
  logic        interrupt;
  logic [11:0] pressed = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference state: frame phase, sync pipe, samples, debounce, queue.
  int         m_ph;
  logic [2:0] m_s1, m_s2;
  logic [2:0] m_samp [4];
  logic [3:0] m_prev, m_stable;
  int         m_cnt;
  logic [3:0] m_q [$];
  logic       m_ov;
  int         m_int;
  logic [3:0] keymap [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                              4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_DIV   (SD),
    .DEBOUNCE   (DB),
    .FIFO_DEPTH (FD),
    .INT_CYCLES (IC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .rd_en     (rd_en),
    .key_data  (key_data),
    .key_valid (key_valid),
    .overflow  (overflow),
    .interrupt (interrupt)
  );

  function automatic logic [2:0] col_of(input logic [3:0] rn, input logic [11:0] pk);
    logic [2:0] v;
    v = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!rn[r] && pk[r*3+c]) v[c] = 1'b0;
    return v;
  endfunction

  assign col_n = col_of(row_n, pressed);

  function automatic logic [3:0] exp_row_n();
    if (m_ph < 0 || m_ph == 4 * SD) return 4'b1110;
    return ~(4'b0001 << (m_ph / SD));
  endfunction

  function automatic logic [3:0] frame_code();
    int         n;
    logic [3:0] code;
    n    = 0;
    code = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!m_samp[r][c]) begin
          n++;
          code = keymap[r*3+c];
        end
    if (n == 0) return 4'hF;
    if (n == 1) return code;
    return 4'hE;
  endfunction

  task automatic model_reset();
    m_ph = -1;
    m_s1 = 3'b111;
    m_s2 = 3'b111;
    for (int r = 0; r < 4; r++) m_samp[r] = 3'b111;
    m_prev   = 4'hF;
    m_stable = 4'hF;
    m_cnt    = 0;
    m_q.delete();
    m_ov  = 1'b0;
    m_int = 0;
  endtask

  task automatic model_step();
    logic [2:0] pins;
    logic [3:0] fc;
    bit         push, pop, acc;
    pins = col_of(exp_row_n(), pressed);
    pop  = rd_en && (m_q.size() > 0);
    push = 0;
    acc  = 0;
    fc   = 4'hF;
    if (m_ph >= 0 && m_ph < 4 * SD && (m_ph % SD) == SD - 1) m_samp[m_ph / SD] = m_s2;
    if (m_ph == 4 * SD) begin
      fc = frame_code();
      if (fc != m_prev) m_cnt = 1;
      else if (m_cnt < DB) m_cnt++;
      m_prev = fc;
      if (m_cnt == DB) begin
        push     = (m_stable == 4'hF) && (fc <= 4'hB);
        m_stable = fc;
      end
    end
    m_s2 = m_s1;
    m_s1 = pins;
    m_ph = (m_ph < 0) ? 0 : (m_ph + 1) % FRAME_LEN;
    if (pop) begin
      void'(m_q.pop_front());
      m_ov = 1'b0;
    end
    if (push) begin
      if (m_q.size() < FD) begin
        m_q.push_back(fc);
        acc = 1;
      end else begin
        m_ov = 1'b1;
      end
    end
    m_int = acc ? IC : ((m_int > 0) ? m_int - 1 : 0);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("row_n", row_n, exp_row_n());
      check("key_valid", key_valid, (m_q.size() > 0));
      check("key_data", key_data, (m_q.size() > 0) ? m_q[0] : 4'hF);
      check("overflow", overflow, m_ov);
      check("interrupt", interrupt, (m_int > 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rd_en = 1'b0;
    end
  endtask

  task automatic frames(input int n);
    cyc(n * FRAME_LEN);
  endtask

  task automatic pulse_rd();
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic press(input int idx);
    pressed      = '0;
    pressed[idx] = 1'b1;
  endtask

  task automatic run_watch(input int n, output int hi, output int first);
    hi    = 0;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      if (interrupt) begin
        hi++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic rand_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rd_en = ($urandom_range(0, 99) < 8);
    end
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int         hi, first, sel, b;
    bit         found;
    logic [3:0] seq1 [4];
    logic [3:0] seq2 [4];
    int         keys1 [5];
    seq1  = '{4'h1, 4'h2, 4'h3, 4'h4};
    seq2  = '{4'h2, 4'h3, 4'h4, 4'h8};
    keys1 = '{0, 1, 2, 3, 6};

    // Reset values
    cyc(3);
    check("rst_row_n", row_n, 4'b1110);
    check("rst_key_data", key_data, 4'hF);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_interrupt", interrupt, 1'b0);
    rst_n = 1'b1;
    frames(2);

    // Key 5 held six frames, then read back
    press(4);
    run_watch(6 * FRAME_LEN, hi, first);
    check("k5_int_width", 8'(hi), 8'd2);
    check("k5_latency_ok", (first > 0 && first <= (DB + 1) * FRAME_LEN + 4), 1'b1);
    check("k5_data", key_data, 4'h5);
    check("k5_valid", key_valid, 1'b1);
    pressed = '0;
    frames(5);
    pulse_rd();
    check("k5_pop_valid", key_valid, 1'b0);
    check("k5_pop_data", key_data, 4'hF);

    // Key 9 bouncing for two frames then stable
    press(8);
    cyc(FRAME_LEN);
    pressed = '0;
    cyc(FRAME_LEN);
    press(8);
    run_watch(7 * FRAME_LEN, hi, first);
    check("k9_int_width", 8'(hi), 8'd2);
    check("k9_data", key_data, 4'h9);
    pressed = '0;
    frames(5);
    pulse_rd();
    check("k9_single_push", key_valid, 1'b0);

    // Two keys together, then release one
    pressed = 12'b000000000011;
    run_watch(6 * FRAME_LEN, hi, first);
    check("multi_no_int", 8'(hi), 8'd0);
    pressed = 12'b000000000001;
    run_watch(6 * FRAME_LEN, hi, first);
    check("multi_to_key_no_int", 8'(hi), 8'd0);
    check("multi_valid", key_valid, 1'b0);
    pressed = '0;
    frames(5);

    // Five presses without reading: the fifth is dropped
    for (int k = 0; k < 5; k++) begin
      press(keys1[k]);
      run_watch(6 * FRAME_LEN, hi, first);
      check("five_int", 8'(hi), (k < 4) ? 8'd2 : 8'd0);
      pressed = '0;
      frames(5);
    end
    check("five_overflow", overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("five_pop_data", key_data, seq1[k]);
      pulse_rd();
      check("five_ovf_after_pop", overflow, 1'b0);
    end
    check("five_empty", key_valid, 1'b0);

    // Full FIFO with push and read in the same cycle
    for (int k = 0; k < 4; k++) begin
      press(keys1[k]);
      frames(6);
      pressed = '0;
      frames(5);
    end
    press(7);
    found = 0;
    for (int i = 0; i < 10 * FRAME_LEN && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_ph == 4 * SD && m_prev == 4'h8 && m_cnt == DB - 1 && m_stable == 4'hF) begin
        rd_en = 1'b1;
        found = 1;
      end
    end
    check("sync_push_window", found, 1'b1);
    @(posedge clk);
    #1 rd_en = 1'b0;
    check("sync_head", key_data, 4'h2);
    check("sync_overflow", overflow, 1'b0);
    check("sync_interrupt", interrupt, 1'b1);
    pressed = '0;
    frames(5);
    for (int k = 0; k < 4; k++) begin
      check("sync_pop_data", key_data, seq2[k]);
      pulse_rd();
    end
    check("sync_empty", key_valid, 1'b0);

    // Asynchronous reset in the middle of row 2 with a key held
    press(5);
    frames(6);
    check("prerst_valid", key_valid, 1'b1);
    for (int i = 0; i < 4 * FRAME_LEN && m_ph != 2 * SD + 1; i++) begin
      @(posedge clk);
      #1;
    end
    check("prerst_in_row2", (m_ph == 2 * SD + 1), 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_row_n", row_n, 4'b1110);
    check("midrst_valid", key_valid, 1'b0);
    check("midrst_data", key_data, 4'hF);
    check("midrst_interrupt", interrupt, 1'b0);
    cyc(3);
    rst_n = 1'b1;
    run_watch(6 * FRAME_LEN, hi, first);
    check("postrst_int", 8'(hi), 8'd2);
    check("postrst_data", key_data, 4'h6);
    pressed = '0;
    frames(5);
    pulse_rd();

    // Randomised presses, chords, bounces and reads against the model
    for (int it = 0; it < 30; it++) begin
      sel     = $urandom_range(0, 99);
      pressed = '0;
      if (sel >= 15 && sel < 35) begin
        pressed[$urandom_range(0, 11)] = 1'b1;
        pressed[$urandom_range(0, 11)] = 1'b1;
      end else if (sel >= 35) begin
        pressed[$urandom_range(0, 11)] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, 11);
        repeat ($urandom_range(4, 40)) begin
          @(posedge clk);
          #1;
          rd_en = 1'b0;
          if ($urandom_range(0, 2) == 0) pressed[b] = ~pressed[b];
        end
      end
      rand_cycles($urandom_range(10, 120));
      pressed = '0;
      rand_cycles($urandom_range(10, 90));
    end

    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
